bpsk_symbol_rx: RTL and testbench

Baseband BPSK symbol receiver: takes signed post-mixer/low-pass samples, finds symbol timing from the first zero crossing, then integrates and dumps over `NUM` samples per symbol to produce hard bit decisions. It is the receive-side counterpart of the modulator's `NUM`-sample symbol counter and sits between the demodulator filter and the frame/bit consumer. It tracks lock and drops back to search after repeated weak symbols.

---
 rtl/bpsk_symbol_rx.sv | 168 ++++++++++++++++
 tb/tb_bpsk_symbol_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_symbol_rx.sv
// Baseband BPSK symbol receiver.
// Finds symbol timing from the first zero crossing after search. Then it
// integrates and dumps over NUM samples per symbol to make hard bit decisions.
// Lock is dropped back to search after MISS_MAX consecutive weak symbols.
module bpsk_symbol_rx #(
   parameter int NUM      = 16,
   parameter int WIDTH    = 8,
   parameter int THRESH   = 64,
   parameter int MISS_MAX = 3
) (
   input  logic                     clk_sig,
   input  logic                     reset_sig,
   input  logic signed [WIDTH-1:0]  sample_sig,
   input  logic                     sample_valid_sig,
   output logic                     bit_sig,
   output logic                     bit_valid_sig,
   output logic                     locked_sig,
   output logic [$clog2(NUM)-1:0]   symbol_phase_sig
);

   localparam int CW     = $clog2(NUM);
   localparam int ACC_W  = WIDTH + CW;
   localparam int MISS_W = $clog2(MISS_MAX + 1);

   localparam logic [CW-1:0]     LAST_CNT   = CW'(NUM - 1);
   localparam logic [CW-1:0]     ONE_CNT    = CW'(1);
   localparam logic [ACC_W:0]    THRESH_V   = (ACC_W + 1)'(THRESH);
   localparam logic [ACC_W:0]    ONE_WIDE   = (ACC_W + 1)'(1);
   localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MISS_MAX);
   localparam logic [MISS_W-1:0] ONE_MISS   = MISS_W'(1);

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_TRACK  = 1'b1
   } state_t;

   // Magnitude of a symbol sum, one bit wider so the most negative total stays positive.
   function automatic logic [ACC_W:0] abs_wide(input logic signed [ACC_W-1:0] v);
      logic [ACC_W:0] ext;
      ext = {v[ACC_W-1], v};
      if (v[ACC_W-1]) begin
         abs_wide = ~ext + ONE_WIDE;
      end else begin
         abs_wide = ext;
      end
   endfunction

   state_t                   state_r, state_n_s;
   logic                     have_prev_r, have_prev_n_s;
   logic                     prev_sign_r, prev_sign_n_s;
   logic signed [ACC_W-1:0]  acc_r, acc_n_s;
   logic [CW-1:0]            cnt_r, cnt_n_s;
   logic [MISS_W-1:0]        miss_r, miss_n_s;
   logic                     bit_r, bit_n_s;
   logic                     bit_valid_r, bit_valid_n_s;
   logic                     locked_r, locked_n_s;
   logic [CW-1:0]            phase_r, phase_n_s;

   logic signed [ACC_W-1:0]  sample_ext_s;
   logic signed [ACC_W-1:0]  sum_s;
   logic                     weak_s;

   assign sample_ext_s = {{CW{sample_sig[WIDTH-1]}}, sample_sig};
   assign sum_s        = acc_r + sample_ext_s;
   assign weak_s       = (abs_wide(sum_s) < THRESH_V);

   // Next-state, accumulator and decision logic; outputs are derived from the next state.
   always_comb begin
      state_n_s     = state_r;
      have_prev_n_s = have_prev_r;
      prev_sign_n_s = prev_sign_r;
      acc_n_s       = acc_r;
      cnt_n_s       = cnt_r;
      miss_n_s      = miss_r;
      bit_n_s       = bit_r;
      bit_valid_n_s = 1'b0;
      case (state_r)
         ST_SEARCH: begin
            if (sample_valid_sig) begin
               if (have_prev_r && (sample_sig[WIDTH-1] != prev_sign_r)) begin
                  // Zero crossing: this sample is the first of a new symbol.
                  acc_n_s   = sample_ext_s;
                  cnt_n_s   = ONE_CNT;
                  state_n_s = ST_TRACK;
               end else begin
                  prev_sign_n_s = sample_sig[WIDTH-1];
                  have_prev_n_s = 1'b1;
               end
            end else begin
               state_n_s = ST_SEARCH;
            end
         end
         ST_TRACK: begin
            if (sample_valid_sig) begin
               if (cnt_r != LAST_CNT) begin
                  acc_n_s = sum_s;
                  cnt_n_s = cnt_r + ONE_CNT;
               end else begin
                  // Dump: a zero sum decides 1.
                  bit_n_s       = ~sum_s[ACC_W-1];
                  bit_valid_n_s = 1'b1;
                  acc_n_s       = '0;
                  cnt_n_s       = {CW{1'b0}};
                  if (weak_s) begin
                     if ((miss_r + ONE_MISS) == MISS_LIMIT) begin
                        state_n_s     = ST_SEARCH;
                        have_prev_n_s = 1'b0;
                        miss_n_s      = {MISS_W{1'b0}};
                     end else begin
                        miss_n_s = miss_r + ONE_MISS;
                     end
                  end else begin
                     miss_n_s = {MISS_W{1'b0}};
                  end
               end
            end else begin
               state_n_s = ST_TRACK;
            end
         end
         default: begin
            state_n_s     = ST_SEARCH;
            have_prev_n_s = 1'b0;
            acc_n_s       = '0;
            cnt_n_s       = {CW{1'b0}};
            miss_n_s      = {MISS_W{1'b0}};
         end
      endcase
      locked_n_s = (state_n_s == ST_TRACK);
      if (locked_n_s) begin
         phase_n_s = cnt_n_s;
      end else begin
         phase_n_s = {CW{1'b0}};
      end
   end

   // State and registered outputs, cleared by the synchronous reset.
   always_ff @(posedge clk_sig) begin
      if (reset_sig) begin
         state_r     <= ST_SEARCH;
         have_prev_r <= 1'b0;
         prev_sign_r <= 1'b0;
         acc_r       <= '0;
         cnt_r       <= {CW{1'b0}};
         miss_r      <= {MISS_W{1'b0}};
         bit_r       <= 1'b0;
         bit_valid_r <= 1'b0;
         locked_r    <= 1'b0;
         phase_r     <= {CW{1'b0}};
      end else begin
         state_r     <= state_n_s;
         have_prev_r <= have_prev_n_s;
         prev_sign_r <= prev_sign_n_s;
         acc_r       <= acc_n_s;
         cnt_r       <= cnt_n_s;
         miss_r      <= miss_n_s;
         bit_r       <= bit_n_s;
         bit_valid_r <= bit_valid_n_s;
         locked_r    <= locked_n_s;
         phase_r     <= phase_n_s;
      end
   end

   assign bit_sig          = bit_r;
   assign bit_valid_sig    = bit_valid_r;
   assign locked_sig       = locked_r;
   assign symbol_phase_sig = phase_r;

endmodule

// File: tb/tb_bpsk_symbol_rx.sv
// Self-checking bench for bpsk_symbol_rx: table of symbols with expected
// decisions feeding a scoreboard, plus hand-written lock/gap/reset sequences.
module tb_bpsk_symbol_rx;

   localparam int NUM   = 16;
   localparam int WIDTH = 8;

   logic                    clk = 1'b0;
   logic                    reset_sig;
   logic signed [WIDTH-1:0] sample_sig;
   logic                    sample_valid_sig;
   logic                    bit_sig;
   logic                    bit_valid_sig;
   logic                    locked_sig;
   logic [$clog2(NUM)-1:0]  symbol_phase_sig;

   bpsk_symbol_rx #(
      .NUM      (16),
      .WIDTH    (8),
      .THRESH   (64),
      .MISS_MAX (3)
   ) dut (
      .clk_sig          (clk),
      .reset_sig        (reset_sig),
      .sample_sig       (sample_sig),
      .sample_valid_sig (sample_valid_sig),
      .bit_sig          (bit_sig),
      .bit_valid_sig    (bit_valid_sig),
      .locked_sig       (locked_sig),
      .symbol_phase_sig (symbol_phase_sig)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic signed [7:0] level;    // first NUM-1 samples of the symbol
      logic signed [7:0] last;     // final sample of the symbol
      logic              exp_bit;
      logic              exp_lock; // locked_sig together with the pulse
   } sym_t;

   typedef struct {
      logic exp_bit;
      logic exp_lock;
   } dec_t;

   sym_t tbl [18];
   dec_t sb_q [$];
   dec_t mon_d;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int cyc       = 0;
   int last_pulse = 0;
   bit have_last  = 1'b0;
   int exp_gap    = 0;

   // Cycle counter used to measure spacing of decision pulses.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic signed [7:0] v, input bit gaps);
      sample_sig       = v;
      sample_valid_sig = 1'b1;
      tick();
      if (gaps) begin
         sample_sig       = 8'($urandom);
         sample_valid_sig = 1'b0;
         tick();
      end
   endtask

   task automatic push(input logic b, input logic l);
      dec_t d;
      d.exp_bit  = b;
      d.exp_lock = l;
      sb_q.push_back(d);
   endtask

   task automatic run_syms(input int first, input int last, input bit gaps);
      for (int s = first; s <= last; s++) begin
         for (int i = 0; i < NUM - 1; i++) drive(tbl[s].level, gaps);
         push(tbl[s].exp_bit, tbl[s].exp_lock);
         drive(tbl[s].last, gaps);
      end
   endtask

   task automatic set_gap(input int g);
      exp_gap   = g;
      have_last = 1'b0;
   endtask

   task automatic pulse_reset();
      reset_sig        = 1'b1;
      sample_valid_sig = 1'b1;
      sample_sig       = 8'($urandom);
      tick();
      reset_sig        = 1'b0;
   endtask

   initial begin
      // Alternating +-50 symbols (sum +-800).
      tbl[0]  = '{-8'sd50,  -8'sd50,  1'b0, 1'b1};
      tbl[1]  = '{ 8'sd50,   8'sd50,  1'b1, 1'b1};
      tbl[2]  = '{-8'sd50,  -8'sd50,  1'b0, 1'b1};
      tbl[3]  = '{ 8'sd50,   8'sd50,  1'b1, 1'b1};
      // Three zero-sum symbols: weak, decide 1, lock drops on the third.
      tbl[4]  = '{ 8'sd0,    8'sd0,   1'b1, 1'b1};
      tbl[5]  = '{ 8'sd0,    8'sd0,   1'b1, 1'b1};
      tbl[6]  = '{ 8'sd0,    8'sd0,   1'b1, 1'b0};
      // Full-scale negative (crossing sample first), then threshold edges.
      tbl[7]  = '{-8'sd128, -8'sd128, 1'b0, 1'b1}; // -2048 strong
      tbl[8]  = '{ 8'sd0,    8'sd0,   1'b1, 1'b1}; // weak, miss 1
      tbl[9]  = '{ 8'sd0,    8'sd0,   1'b1, 1'b1}; // weak, miss 2
      tbl[10] = '{-8'sd128, -8'sd128, 1'b0, 1'b1}; // strong clears misses
      tbl[11] = '{ 8'sd4,    8'sd3,   1'b1, 1'b1}; // +63 weak, miss 1
      tbl[12] = '{-8'sd4,   -8'sd3,   1'b0, 1'b1}; // -63 weak, miss 2
      tbl[13] = '{-8'sd4,   -8'sd4,   1'b0, 1'b1}; // -64 strong
      tbl[14] = '{ 8'sd4,    8'sd4,   1'b1, 1'b1}; // +64 strong
      tbl[15] = '{ 8'sd4,    8'sd3,   1'b1, 1'b1}; // weak, miss 1
      tbl[16] = '{ 8'sd4,    8'sd3,   1'b1, 1'b1}; // weak, miss 2
      tbl[17] = '{ 8'sd4,    8'sd3,   1'b1, 1'b0}; // weak, drop

      reset_sig        = 1'b1;
      sample_valid_sig = 1'b1;
      sample_sig       = 8'sd0;

      // Decision monitor: pops the scoreboard on every pulse.
      fork
         forever begin
            @(negedge clk);
            if (bit_valid_sig === 1'b1) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_pulse", 32'(bit_valid_sig), 32'd0);
               end else begin
                  mon_d = sb_q.pop_front();
                  check("bit", 32'(bit_sig), 32'(mon_d.exp_bit));
                  check("locked_at_pulse", 32'(locked_sig), 32'(mon_d.exp_lock));
                  check("phase_at_pulse", 32'(symbol_phase_sig), 32'd0);
               end
               if (exp_gap != 0 && have_last) begin
                  check("pulse_gap", 32'(cyc - last_pulse), 32'(exp_gap));
               end
               last_pulse = cyc;
               have_last  = 1'b1;
            end
         end
      join_none

      // Reset values with random samples and valid high.
      for (int i = 0; i < 3; i++) begin
         sample_sig = 8'($urandom);
         tick();
         check("rst_bit",    32'(bit_sig), 32'd0);
         check("rst_valid",  32'(bit_valid_sig), 32'd0);
         check("rst_locked", 32'(locked_sig), 32'd0);
         check("rst_phase",  32'(symbol_phase_sig), 32'd0);
      end
      reset_sig = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(8'sd30, 1'b0);
         check("search_locked", 32'(locked_sig), 32'd0);
         check("search_phase",  32'(symbol_phase_sig), 32'd0);
      end

      // Lock and alternate, back-to-back samples.
      pulse_reset();
      set_gap(16);
      for (int i = 0; i < NUM; i++) drive(-8'sd50, 1'b0);
      check("prelock_locked", 32'(locked_sig), 32'd0);
      drive(8'sd50, 1'b0);
      check("lock_rise", 32'(locked_sig), 32'd1);
      check("phase_after_cross", 32'(symbol_phase_sig), 32'd1);
      for (int i = 0; i < NUM - 2; i++) drive(8'sd50, 1'b0);
      check("phase_mid", 32'(symbol_phase_sig), 32'd15);
      push(1'b1, 1'b1);
      drive(8'sd50, 1'b0);
      run_syms(0, 3, 1'b0);

      // Weak-symbol drop.
      run_syms(4, 6, 1'b0);
      sample_valid_sig = 1'b0;
      tick();
      check("drop_locked", 32'(locked_sig), 32'd0);
      check("drop_phase",  32'(symbol_phase_sig), 32'd0);

      // Full-scale negative and threshold boundaries.
      set_gap(16);
      drive(8'sd50, 1'b0);
      drive(8'sd50, 1'b0);
      check("research_locked", 32'(locked_sig), 32'd0);
      run_syms(7, 17, 1'b0);
      sample_valid_sig = 1'b0;
      tick();
      check("thresh_drop_locked", 32'(locked_sig), 32'd0);

      // Valid gaps every other cycle.
      pulse_reset();
      set_gap(32);
      for (int i = 0; i < NUM; i++) drive(-8'sd50, 1'b1);
      sample_sig       = 8'sd50;
      sample_valid_sig = 1'b1;
      tick();
      check("gap_lock_rise", 32'(locked_sig), 32'd1);
      check("gap_phase_cross", 32'(symbol_phase_sig), 32'd1);
      sample_sig       = 8'($urandom);
      sample_valid_sig = 1'b0;
      tick();
      check("gap_phase_hold", 32'(symbol_phase_sig), 32'd1);
      for (int i = 0; i < NUM - 2; i++) drive(8'sd50, 1'b1);
      push(1'b1, 1'b1);
      drive(8'sd50, 1'b1);
      run_syms(0, 3, 1'b1);

      // Reset mid-symbol, then relock.
      set_gap(0);
      for (int i = 0; i < 7; i++) drive(-8'sd50, 1'b0);
      check("mid_phase", 32'(symbol_phase_sig), 32'd7);
      check("mid_locked", 32'(locked_sig), 32'd1);
      reset_sig        = 1'b1;
      sample_sig       = -8'sd50;
      sample_valid_sig = 1'b1;
      tick();
      reset_sig = 1'b0;
      check("mid_rst_valid",  32'(bit_valid_sig), 32'd0);
      check("mid_rst_locked", 32'(locked_sig), 32'd0);
      check("mid_rst_phase",  32'(symbol_phase_sig), 32'd0);
      check("mid_rst_bit",    32'(bit_sig), 32'd0);
      drive(8'sd50, 1'b0);
      check("relock_load", 32'(locked_sig), 32'd0);
      drive(-8'sd50, 1'b0);
      check("relock_locked", 32'(locked_sig), 32'd1);
      check("relock_phase",  32'(symbol_phase_sig), 32'd1);
      for (int i = 0; i < NUM - 2; i++) drive(-8'sd50, 1'b0);
      push(1'b0, 1'b1);
      drive(-8'sd50, 1'b0);
      sample_valid_sig = 1'b0;
      tick();
      tick();
      check("bit_hold",       32'(bit_sig), 32'd0);
      check("valid_one_wide", 32'(bit_valid_sig), 32'd0);
      check("still_locked",   32'(locked_sig), 32'd1);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
